bdi_key_feeder: RTL
===================

BDI_KEY_FEEDER -- requirements
Module: bdi_key_feeder

Interface
- REQ-001 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high.
- REQ-002 SHALL have cmd_valid in 1, cmd_ready out 1: segment command handshake.
- REQ-003 SHALL have cmd_type in 4, cmd_len in 16 (segment length, bytes), cmd_last in 1 (final segment of message), cmd_decrypt in 1: command fields.
- REQ-004 SHALL have din in 32, din_valid in 1, din_ready out 1: raw word stream, byte 0 in [31:24].
- REQ-005 SHALL have key out 32, key_valid out 1, key_ready in 1, key_update out 1: key port to the AEAD controller.
- REQ-006 SHALL have bdi out 32, bdi_valid out 1, bdi_ready in 1: block data port.
- REQ-007 SHALL have bdi_type out 4, bdi_eot out 1, bdi_eoi out 1, bdi_partial out 1, bdi_size out 3, decrypt out 1: bdi sideband.

Function
- REQ-008 SHALL use type codes AD=0001, PT=0100, CT=0101, TAG=1000, NPUB=1101, KEY=1100.
- REQ-009 SHALL implement FSM states IDLE, KEY, DATA, EMPTY; cmd_ready=1 only in IDLE.
- REQ-010 On cmd accept, SHALL latch cmd_type and cmd_last; SHALL latch cmd_decrypt into decrypt only when type=NPUB.
- REQ-011 On cmd accept, SHALL go to KEY if type=KEY (cmd_len ignored, 4 words fixed), EMPTY if cmd_len=0 and cmd_last=1, stay IDLE if cmd_len=0 and cmd_last=0, else DATA.
- REQ-012 On DATA entry, SHALL load word counter = ceil(cmd_len/4)-1 and last-word size = cmd_len mod 4 (0 maps to 4).
- REQ-013 In KEY: key=din, key_valid=din_valid, din_ready=key_ready, key_update=1; bdi_valid=0.
- REQ-014 KEY SHALL count 4 transfers (key_valid&key_ready) and return to IDLE after the 4th.
- REQ-015 In DATA: bdi_valid=din_valid, din_ready=bdi_ready, bdi_type=latched type; word transfers when bdi_valid&bdi_ready.
- REQ-016 Non-last DATA word SHALL drive bdi_size=4, bdi_partial=0, bdi_eot=0, bdi_eoi=0.
- REQ-017 Last DATA word SHALL drive bdi_eot=1, bdi_eoi=cmd_last, bdi_size=last-word size, bdi_partial=(size<4), and zero unused low-order bytes of bdi.
- REQ-018 After the last DATA word transfers, SHALL return to IDLE; a new command SHALL be accepted no earlier than the next cycle.
- REQ-019 In EMPTY: bdi_valid=1, bdi=0, bdi_size=0, bdi_partial=0, bdi_eot=1, bdi_eoi=1, din_ready=0; on bdi_ready go to IDLE.
- REQ-020 Outside KEY/DATA, SHALL drive din_ready=0.
- REQ-021 SHALL hold bdi and sideband stable while bdi_valid=1 and bdi_ready=0 (given stable din).
- REQ-022 Word counter SHALL be 14 bits, decrement by one per transfer, no wrap (max 16384 words).
- REQ-023 When simultaneously bdi_ready=1 and din_valid=0, SHALL make no transfer and leave counter unchanged.

Reset
- REQ-024 While rst=1 at a clk edge, SHALL enter IDLE and clear counters, latched type, cmd_last and decrypt to 0.
- REQ-025 Reset values: cmd_ready=0 during rst, 1 the cycle after; din_ready, key_valid, key_update, bdi_valid, bdi_eot, bdi_eoi, bdi_partial, decrypt=0; bdi_size=0; bdi, key=0.
- REQ-026 Reset mid-segment SHALL abandon the segment; no remaining words SHALL be emitted.

Structure
- REQ-027 Type codes, KEY_WORDS=4 and word width SHALL live in shared package aead_pkg.
- REQ-028 Counters SHALL be built from the existing d_ff enable register; no other sub-module.

Verification
- REQ-029 KEY cmd, 4 din words A0..A3, key_ready=1 -> key_update=1 for 4 cycles, key=A0..A3, IDLE, cmd_ready=1.
- REQ-030 NPUB cmd_len=16, cmd_decrypt=1 -> 4 bdi words type=1101, eot only on 4th, size=4, decrypt=1 afterwards.
- REQ-031 AD cmd_len=5, cmd_last=0, din 11223344, 55667788 -> 2nd bdi=55000000, size=1, partial=1, eot=1, eoi=0.
- REQ-032 PT cmd_len=0, cmd_last=1 -> one bdi word 0, size=0, eot=1, eoi=1, din_ready stays 0.
- REQ-033 PT cmd_len=12, bdi_ready toggling 1/0 -> exactly 3 transfers, outputs stable while stalled.
- REQ-034 rst asserted after 2 of 4 words -> bdi_valid=0 next cycle, then IDLE, cmd_ready=1, no stale words.

Source files
------------

// File: rtl/aead_pkg.sv
// Shared AEAD definitions: segment type codes, key length and datapath widths.
package aead_pkg;

  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 4;
  localparam int CNT_W     = 14;

  localparam logic [3:0] TYPE_AD   = 4'b0001;
  localparam logic [3:0] TYPE_PT   = 4'b0100;
  localparam logic [3:0] TYPE_CT   = 4'b0101;
  localparam logic [3:0] TYPE_TAG  = 4'b1000;
  localparam logic [3:0] TYPE_NPUB = 4'b1101;
  localparam logic [3:0] TYPE_KEY  = 4'b1100;

endpackage

// File: rtl/d_ff.sv
// Enable register with synchronous active-high clear; used for the word counters.
module d_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear on reset, otherwise load d when enabled.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/bdi_key_feeder.sv
// Splits a raw word stream into key words and bdi segments under command control,
// generating eot/eoi/size sideband and masking the unused bytes of the final word.
module bdi_key_feeder
  import aead_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_type,
  input  logic [15:0]         cmd_len,
  input  logic                cmd_last,
  input  logic                cmd_decrypt,
  input  logic [WORD_W-1:0]   din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [WORD_W-1:0]   key,
  output logic                key_valid,
  input  logic                key_ready,
  output logic                key_update,
  output logic [WORD_W-1:0]   bdi,
  output logic                bdi_valid,
  input  logic                bdi_ready,
  output logic [3:0]          bdi_type,
  output logic                bdi_eot,
  output logic                bdi_eoi,
  output logic                bdi_partial,
  output logic [2:0]          bdi_size,
  output logic                decrypt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_KEY   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_EMPTY = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       type_q, type_d;
  logic             last_q, last_d;
  logic             dec_q, dec_d;
  logic [2:0]       lsize_q, lsize_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_en;
  logic [1:0]       kcnt_q, kcnt_d;
  logic             kcnt_en;
  logic             cmd_acc, key_xfer, bdi_xfer, is_last;
  logic [16:0]      len_words;

  // Keep the valid bytes (MSB-first) of a final word holding 1..4 bytes.
  function automatic logic [WORD_W-1:0] tail_mask(input logic [2:0] size);
    case (size)
      3'd1:    tail_mask = 32'hFF00_0000;
      3'd2:    tail_mask = 32'hFFFF_0000;
      3'd3:    tail_mask = 32'hFFFF_FF00;
      default: tail_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  assign cmd_acc   = cmd_valid & cmd_ready;
  assign len_words = ({1'b0, cmd_len} + 17'd3) >> 2;
  assign is_last   = (cnt_q == '0);
  assign key_xfer  = (state_q == S_KEY) & din_valid & key_ready;
  assign bdi_xfer  = (state_q == S_DATA) & din_valid & bdi_ready;
  assign decrypt   = dec_q;

  // Remaining-word counter for the current DATA segment (0 marks the last word).
  d_ff #(.W(CNT_W)) u_word_cnt (
    .clk(clk), .rst(rst), .en(cnt_en), .d(cnt_d), .q(cnt_q)
  );

  // Count of key words already handed to the controller.
  d_ff #(.W(2)) u_key_cnt (
    .clk(clk), .rst(rst), .en(kcnt_en), .d(kcnt_d), .q(kcnt_q)
  );

  // Next-state, command latching and counter load/decrement decisions.
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    last_d  = last_q;
    dec_d   = dec_q;
    lsize_d = lsize_q;
    cnt_d   = cnt_q - CNT_W'(1);
    cnt_en  = 1'b0;
    kcnt_d  = kcnt_q + 2'd1;
    kcnt_en = key_xfer;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          type_d = cmd_type;
          last_d = cmd_last;
          if (cmd_type == TYPE_NPUB) dec_d = cmd_decrypt;
          if (cmd_type == TYPE_KEY) begin
            state_d = S_KEY;
            kcnt_d  = 2'd0;
            kcnt_en = 1'b1;
          end else if (cmd_len == 16'd0) begin
            if (cmd_last) state_d = S_EMPTY;
          end else begin
            state_d = S_DATA;
            cnt_d   = CNT_W'(len_words - 17'd1);
            cnt_en  = 1'b1;
            lsize_d = (cmd_len[1:0] == 2'd0) ? 3'd4 : {1'b0, cmd_len[1:0]};
          end
        end
      end
      S_KEY: begin
        if (key_xfer && (kcnt_q == 2'(KEY_WORDS - 1))) state_d = S_IDLE;
      end
      S_DATA: begin
        if (bdi_xfer) begin
          if (is_last) state_d = S_IDLE;
          else         cnt_en  = 1'b1;
        end
      end
      default: begin
        if (bdi_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State and latched command fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= 4'd0;
      last_q  <= 1'b0;
      dec_q   <= 1'b0;
      lsize_q <= 3'd0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      last_q  <= last_d;
      dec_q   <= dec_d;
      lsize_q <= lsize_d;
    end
  end

  // Output steering: key port in KEY, bdi port in DATA/EMPTY, idle elsewhere.
  always_comb begin
    cmd_ready   = (state_q == S_IDLE) & ~rst;
    din_ready   = 1'b0;
    key         = '0;
    key_valid   = 1'b0;
    key_update  = 1'b0;
    bdi         = '0;
    bdi_valid   = 1'b0;
    bdi_type    = 4'd0;
    bdi_eot     = 1'b0;
    bdi_eoi     = 1'b0;
    bdi_partial = 1'b0;
    bdi_size    = 3'd0;
    case (state_q)
      S_KEY: begin
        key        = din;
        key_valid  = din_valid;
        din_ready  = key_ready;
        key_update = 1'b1;
      end
      S_DATA: begin
        bdi_valid = din_valid;
        din_ready = bdi_ready;
        bdi_type  = type_q;
        if (is_last) begin
          bdi         = din & tail_mask(lsize_q);
          bdi_size    = lsize_q;
          bdi_partial = (lsize_q < 3'd4);
          bdi_eot     = 1'b1;
          bdi_eoi     = last_q;
        end else begin
          bdi      = din;
          bdi_size = 3'd4;
        end
      end
      S_EMPTY: begin
        bdi_valid = 1'b1;
        bdi_type  = type_q;
        bdi_eot   = 1'b1;
        bdi_eoi   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
